// File: rtl/fsm_seq.sv
// fsm_seq: parametrised START-triggered output sequencer with abort and busy/done status.
// Optional feature macro: FSM_SEQ_RETRIGGER_EN (back-to-back sequences without an idle gap).
module fsm_seq #(
    parameter int N_OUT  = 2,
    parameter int DWELL  = 1,
    parameter int ONEHOT = 0,
    localparam int SW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    output logic [N_OUT-1:0] OUT_SIG,
    output logic [SW-1:0]    STEP,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(N_OUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [SW-1:0]    step_q,  step_d;
    logic [N_OUT-1:0] out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [SW-1:0]    step_inc;

    // Output pattern for a given step: cumulative fill or a single walking bit.
    function automatic logic [N_OUT-1:0] pattern(input logic [SW-1:0] s);
        logic [N_OUT-1:0] p;
        p = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (ONEHOT != 0) begin
                p[i] = (i == int'(s));
            end else begin
                p[i] = (i <= int'(s));
            end
        end
        return p;
    endfunction

    assign step_inc = step_q + SW'(1);

    // Next-state logic; abort wins over every other RUN transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    step_d  = '0;
                    out_d   = pattern('0);
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                    out_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (step_q != STEP_LAST) begin
                    cnt_d  = '0;
                    step_d = step_inc;
                    out_d  = pattern(step_inc);
                end else begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    step_d = '0;
`ifdef FSM_SEQ_RETRIGGER_EN
                    if (START) begin
                        state_d = RUN;
                        out_d   = pattern('0);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        out_d   = '0;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    out_d   = '0;
                    busy_d  = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                step_d  = '0;
                out_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything without a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign OUT_SIG = out_q;
    assign STEP    = step_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule
